// File: rtl/kernel_ctrl.sv
// Sequencer for the sliding-window kernel: joins the per-row line-buffer streams,
// tracks column/band position over a frame and strobes complete in-image windows.
module kernel_ctrl #(
  parameter int unsigned BLOCK_WIDTH  = 3,
  parameter int unsigned BLOCK_HEIGHT = 3,
  parameter int unsigned IMG_WIDTH    = 64,
  parameter int unsigned IMG_HEIGHT   = 48,
  parameter int unsigned COL_W        = $clog2(IMG_WIDTH),
  parameter int unsigned ROW_W        = $clog2(IMG_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BLOCK_HEIGHT-1:0] row_valid,
  output logic [BLOCK_HEIGHT-1:0] row_ready,
  output logic [BLOCK_HEIGHT-1:0] kernel_in_valid,
  input  logic [BLOCK_HEIGHT-1:0] kernel_in_ready,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [COL_W-1:0]        win_x,
  output logic [ROW_W-1:0]        win_y,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int unsigned LAST_COL  = IMG_WIDTH - 1;
  localparam int unsigned LAST_BAND = IMG_HEIGHT - BLOCK_HEIGHT;
  localparam int unsigned WARM_COLS = BLOCK_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] band;

  logic all_valid;
  logic stall;
  logic feed;
  logic fire;
  logic last_col;
  logic last_fire;
  logic win_ok;

  // Join: lanes only advance when every row has data and every kernel lane accepts.
  assign all_valid = &row_valid;
  assign stall     = win_valid && !win_ready;
  assign feed      = (state == RUN) && all_valid && !stall;
  assign fire      = feed && (&kernel_in_ready);
  assign last_col  = (col == COL_W'(LAST_COL));
  assign last_fire = fire && last_col && (band == ROW_W'(LAST_BAND));
  assign win_ok    = (col >= COL_W'(WARM_COLS));

  assign kernel_in_valid = {BLOCK_HEIGHT{feed}};
  assign row_ready       = {BLOCK_HEIGHT{fire}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      band       <= '0;
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            col   <= '0;
            band  <= '0;
          end
        end
        RUN: begin
          if (fire) begin
            if (last_col) begin
              col  <= '0;
              band <= last_fire ? '0 : band + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
          end
          if (last_fire) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Wait for the final window to be taken before reporting the frame done.
          if (!win_valid || win_ready) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Window strobe lines up with the kernel's registered output pixels.
      if (fire && win_ok) begin
        win_valid <= 1'b1;
        win_x     <= col - COL_W'(WARM_COLS);
        win_y     <= band;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/kernel_ctrl.md
Name: kernel_ctrl

Overview:
- Sequencer for the sliding-window kernel (BLOCK_HEIGHT rows in parallel, BLOCK_WIDTH-column shift window).
- Joins the per-row line-buffer streams so all rows advance in lockstep, and gates the kernel's per-row in_valid.
- Tracks column and row-band position over one frame, and suppresses warm-up columns.
- Emits a window-valid strobe with top-left coordinates, plus frame start/stop control.

Parameters:
- BLOCK_WIDTH, 3, window width in columns.
- BLOCK_HEIGHT, 3, window height; number of parallel row streams.
- IMG_WIDTH, 64, pixels per image row.
- IMG_HEIGHT, 48, image rows.
- COL_W, $clog2(IMG_WIDTH), column counter / win_x width.
- ROW_W, $clog2(IMG_HEIGHT), band counter / win_y width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- row_valid  in  BLOCK_HEIGHT  per-row line-buffer data valid.
- row_ready  out  BLOCK_HEIGHT  per-row pop to line buffers.
- kernel_in_valid  out  BLOCK_HEIGHT  drives the kernel's in_valid.
- kernel_in_ready  in  BLOCK_HEIGHT  kernel's in_ready.
- win_valid  out  1  kernel out_pixels hold a complete in-image window.
- win_ready  in  1  downstream accepts window.
- win_x  out  COL_W  window top-left column.
- win_y  out  ROW_W  window top-left row (band index).
- busy  out  1  high in RUN or DRAIN.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset values:
  - state=IDLE; col=0; band=0.
  - win_valid=0; win_x=0; win_y=0.
  - frame_done=0; busy=0.
  - row_ready=0; kernel_in_valid=0.
- States:
  - IDLE: start -> RUN; counters cleared.
  - RUN -> DRAIN on the final fire (col==IMG_WIDTH-1 and band==IMG_HEIGHT-BLOCK_HEIGHT).
  - DRAIN -> IDLE when !win_valid, or win_valid&&win_ready. frame_done pulses 1 in the cycle after this transition.
- start outside IDLE is ignored.
- Join:
  - all_valid = &row_valid.
  - stall = win_valid && !win_ready.
  - kernel_in_valid = {BLOCK_HEIGHT{RUN && all_valid && !stall}}. It must not depend on kernel_in_ready.
  - fire = RUN && all_valid && &kernel_in_ready && !stall.
  - row_ready = {BLOCK_HEIGHT{fire}}.
  - A partial set of valid rows or ready lanes never pops any row.
- Counters, updated on fire only:
  - col increments; at IMG_WIDTH-1 it wraps to 0 and band increments.
  - band range is 0..IMG_HEIGHT-BLOCK_HEIGHT.
- Window strobe (registered, 1-cycle latency after fire; aligns with the kernel's registered out_pixels):
  - On fire with col>=BLOCK_WIDTH-1: win_valid<=1, win_x<=col-(BLOCK_WIDTH-1), win_y<=band.
  - Else, if win_ready: win_valid<=0.
  - win_x and win_y hold while win_valid && !win_ready.
- Warm-up: the first BLOCK_WIDTH-1 fires of every band produce no window. This includes band 0 and every wrap.
- Totals:
  - Windows per frame = (IMG_WIDTH-BLOCK_WIDTH+1)*(IMG_HEIGHT-BLOCK_HEIGHT+1).
  - Fires per frame = IMG_WIDTH*(IMG_HEIGHT-BLOCK_HEIGHT+1).
- busy = (state!=IDLE), registered.
- Reset mid-frame: next cycle all outputs return to reset values. A following start restarts at col=0, band=0.
- Simultaneous fire and win_ready while win_valid: the new window replaces the old one, and win_valid stays 1.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=5, BLOCK 3x3):
- Free-running frame. Stimulus: start, row_valid=111, kernel_in_ready=111, win_ready=1. Required response:
  - 24 fires, 18 win_valid cycles.
  - First window (x=0,y=0) one cycle after the 3rd fire; last window (x=5,y=2).
  - frame_done pulses once; busy falls with it.
- Partial row valid. Stimulus: row_valid=110 for 5 cycles mid-row. Required response: row_ready=000, kernel_in_valid=000, col/band unchanged; resumes at the same col with 111.
- Kernel backpressure. Stimulus: kernel_in_ready=110 with row_valid=111. Required response: kernel_in_valid=111, row_ready=000, no count advance.
- Downstream stall. Stimulus: win_ready=0 for 4 cycles while win_valid=1 at x=2,y=1. Required response: win_valid, win_x and win_y are held; no fires; release yields x=3,y=1 next.
- Band wrap. Required response: after x=5,y=0 the next two fires give no window; the next window is x=0,y=1.
- Control edges. Stimulus: start asserted during RUN. Required response: ignored. Stimulus: rst at band 1, then start. Required response: busy=0 and win_valid=0 the cycle after rst; the first window after start is x=0,y=0.
